rsa_const_unit: RTL and testbench

RSA_CONST_UNIT -- requirements
Module: rsa_const_unit

---
 rtl/rsa_const_unit.sv | 122 ++++++++++++
 tb/tb_rsa_const_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rsa_const_unit.sv
// Computes the Montgomery constant 2^(2N) mod M, with N = WIDTH+2 digits.
// It performs one modular doubling per enabled cycle, for 2N cycles.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; Const holds the last completed result
//   RUN   | doubling r modulo m_q, one step per ena-qualified cycle
module rsa_const_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Const,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int N     = WIDTH + 2;
  localparam int STEPS = 2 * N;
  localparam int CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_step;

  // r stays below m_q, so doubling its low WIDTH bits cannot lose a carry.
  assign t      = {r_q[WIDTH-1:0], 1'b0};
  assign r_step = (t >= {1'b0, m_q}) ? (t - {1'b0, m_q}) : t;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    m_d     = m_q;
    const_d = const_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      r_d     = '0;
      const_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_d   = M;
            cnt_d = '0;
            err_d = 1'b0;
            if (!M[0]) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              r_d     = {{WIDTH{1'b0}}, (M != WIDTH'(1))};
            end
          end
        end
        RUN: begin
          r_d   = r_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            const_d = r_step[WIDTH-1:0];
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q   <= '0;
      r_q     <= '0;
      m_q     <= '0;
      const_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      m_q     <= m_d;
      const_q <= const_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Const = const_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rsa_const_unit.sv
// Directed bench for rsa_const_unit (WIDTH=8, 20 doubling steps).
// Expected constants are 2^20 mod M, worked out by hand.
module tb_rsa_const_unit;

  logic       clk;
  logic       rstb;
  logic       ena;
  logic       clear;
  logic       start;
  logic [7:0] M;
  logic [7:0] Const;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_mis = 0;

  rsa_const_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .ena   (ena),
    .clear (clear),
    .start (start),
    .M     (M),
    .Const (Const),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_run(input logic [7:0] m, input int hold, input bit disturb,
                        input logic [7:0] exp);
    int cnt;
    int bcnt;
    M     = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    bcnt  = 0;
    while (!done && cnt < 300) begin
      if (busy) bcnt++;
      ena = !(cnt >= 5 && cnt < 5 + hold);
      if (disturb && cnt == 3) begin
        start = 1'b1;
        M     = 8'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    ena   = 1'b1;
    start = 1'b0;
    check("done_latency", cnt, 20 + hold);
    check("busy_cycles", bcnt, 20 + hold);
    check("const", Const, exp);
    check("err_valid", err, 0);
    check("busy_at_done", busy, 0);
  endtask

  task automatic do_invalid(input logic [7:0] m, input logic [7:0] keep);
    M     = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("inv_done", done, 1);
    check("inv_err", err, 1);
    check("inv_busy", busy, 0);
    check("inv_const", Const, keep);
    @(negedge clk);
    check("inv_done_once", done, 0);
    check("inv_err_sticky", err, 1);
    check("inv_busy_after", busy, 0);
  endtask

  // kind 0: clear abort, kind 1: rstb pulse
  task automatic do_abort(input int kind, input int at);
    int cnt;
    int dcnt;
    M     = 8'd251;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (cnt < at) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_busy_before", busy, 1);
    if (kind == 0) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end else begin
      rstb = 1'b0;
      #2;
      check("rst_busy_async", busy, 0);
      @(negedge clk);
      rstb = 1'b1;
    end
    check("abort_busy", busy, 0);
    check("abort_const", Const, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_idle", busy, 0);
  endtask

  initial begin
    rstb  = 1'b0;
    ena   = 1'b1;
    clear = 1'b0;
    start = 1'b0;
    M     = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_const", Const, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rstb = 1'b1;
    @(negedge clk);

    do_run(8'd251, 0, 1'b0, 8'd149);
    @(negedge clk);
    check("single_done", done, 0);

    do_run(8'd13, 0, 1'b0, 8'd9);
    do_run(8'd255, 0, 1'b0, 8'd16);
    do_run(8'd1, 0, 1'b0, 8'd0);
    @(negedge clk);

    do_run(8'd251, 0, 1'b0, 8'd149);
    @(negedge clk);
    do_invalid(8'd8, 8'd149);
    do_invalid(8'd0, 8'd149);

    do_run(8'd13, 0, 1'b0, 8'd9);
    @(negedge clk);
    do_run(8'd251, int'($urandom_range(1, 6)), 1'b0, 8'd149);
    @(negedge clk);

    do_run(8'd255, 0, 1'b0, 8'd16);
    @(negedge clk);
    do_run(8'd251, 0, 1'b1, 8'd149);
    @(negedge clk);
    check("disturb_single_done", done, 0);
    check("disturb_idle", busy, 0);

    do_abort(0, 7);
    do_run(8'd251, 0, 1'b0, 8'd149);
    @(negedge clk);
    do_abort(1, 12);
    do_run(8'd13, 0, 1'b0, 8'd9);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
